// File: rtl/pcs_sched_pkg.sv
// pcs_sched_pkg: shared TX/RX scheduler state type and gearbox sequence constants
package pcs_sched_pkg;
  localparam int TX_SEQ_LAST = 32;
  localparam int TX_SEQ_W = 6;
  typedef enum logic [1:0] {
    WAIT_READY = 2'd0,
    STARTUP    = 2'd1,
    RUN        = 2'd2
  } tx_sched_state_t;
endpackage

// File: rtl/pcs_tx_seq_counter.sv
// pcs_tx_seq_counter: free-running 0..LAST gearbox sequence counter with registered last-value decode and sync clear
module pcs_tx_seq_counter
  import pcs_sched_pkg::*;
#(
  parameter int W    = TX_SEQ_W,
  parameter int LAST = TX_SEQ_LAST
) (
  input  logic         i_clk,
  input  logic         i_reset,
  input  logic         i_clear,
  input  logic         i_en,
  output logic [W-1:0] o_seq,
  output logic         o_last
);
  logic [W-1:0] seq_d;
  // next value: clear wins, hold when disabled, wrap LAST straight to 0
  always_comb begin
    seq_d = i_clear ? '0 : !i_en ? o_seq : (o_seq == W'(LAST)) ? '0 : o_seq + 1'b1;
  end
  // last flag decoded from the next value so it lines up with the registered count
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_seq  <= '0;
      o_last <= 1'b0;
    end else begin
      o_seq  <= seq_d;
      o_last <= (seq_d == W'(LAST));
    end
  end
endmodule

// File: rtl/pcs_tx_scheduler.sv
// pcs_tx_scheduler: 64b/66b TX sequencing (gearbox sequence/pause, encoder init/reset, MAC consume); PCS_TX_SCHED_STATS_EN adds pause/relink counters
module pcs_tx_scheduler
  import pcs_sched_pkg::*;
#(
  parameter int DATA_WIDTH     = 32,
  parameter int STARTUP_CYCLES = 16,
  parameter int SEQ_LAST       = TX_SEQ_LAST
) (
  input  logic                i_clk,
  input  logic                i_reset,
  input  logic                i_gt_ready,
  output logic [TX_SEQ_W-1:0] o_tx_sequence,
  output logic                o_tx_pause,
  output logic                o_init_done,
  output logic                o_encoder_reset,
  output logic                o_mac_ready,
  output logic [1:0]          o_state
`ifdef PCS_TX_SCHED_STATS_EN
  ,
  output logic [31:0]         o_pause_count,
  output logic [15:0]         o_relink_count
`endif
);
  if (DATA_WIDTH != 32 && DATA_WIDTH != 64) begin : g_bad_width
    $error("DATA_WIDTH must be 32 or 64");
  end
  if (STARTUP_CYCLES < 1 || STARTUP_CYCLES > 255) begin : g_bad_startup
    $error("STARTUP_CYCLES must be in 1..255");
  end
  if (SEQ_LAST < 1 || SEQ_LAST >= (1 << TX_SEQ_W)) begin : g_bad_seq
    $error("SEQ_LAST must fit the sequence width");
  end
  tx_sched_state_t state, state_d;
  logic [7:0] cnt, cnt_d;
  logic seq_clear;
  assign o_state = state;
  assign seq_clear = (state == WAIT_READY) || (state_d == WAIT_READY);
  pcs_tx_seq_counter #(.W(TX_SEQ_W), .LAST(SEQ_LAST)) u_seq (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_clear (seq_clear),
    .i_en    (1'b1),
    .o_seq   (o_tx_sequence),
    .o_last  (o_tx_pause)
  );
  // next state and saturating startup count; losing gt_ready beats RUN entry
  always_comb begin
    state_d = !i_gt_ready ? WAIT_READY
            : (state == WAIT_READY) ? STARTUP
            : (state == STARTUP && cnt == 8'(STARTUP_CYCLES) && o_tx_sequence == TX_SEQ_W'(SEQ_LAST)) ? RUN
            : state;
    cnt_d = (state_d == WAIT_READY) ? 8'd0
          : (state == STARTUP && cnt != 8'(STARTUP_CYCLES)) ? cnt + 8'd1
          : cnt;
  end
  // registered outputs; MAC is held off in the cycle whose next sequence is the pause slot
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state           <= WAIT_READY;
      cnt             <= 8'd0;
      o_init_done     <= 1'b0;
      o_encoder_reset <= 1'b1;
      o_mac_ready     <= 1'b0;
    end else begin
      state           <= state_d;
      cnt             <= cnt_d;
      o_init_done     <= (state_d == RUN);
      o_encoder_reset <= (state_d == WAIT_READY);
      o_mac_ready     <= (state_d == RUN) && (o_tx_sequence != TX_SEQ_W'(SEQ_LAST - 1));
    end
  end
`ifdef PCS_TX_SCHED_STATS_EN
  // wrapping pause-cycle count and saturating count of link drops out of RUN
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      o_pause_count  <= '0;
      o_relink_count <= '0;
    end else begin
      o_pause_count  <= o_pause_count + 32'(o_tx_pause);
      if (state == RUN && state_d == WAIT_READY && !(&o_relink_count))
        o_relink_count <= o_relink_count + 16'd1;
    end
  end
`endif
endmodule
